// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: pointer sizing and read-mode constants.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // One extra bit above the address width serves as the wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for the FIFO: synchronous write, asynchronous read.
module fifo_ram #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, level flags, sticky
// overflow/underflow and a choice of registered or fall-through read data.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = FIFO_STD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  clr_err,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_accept, rd_accept;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Wrap bits are kept for pointer integrity; occupancy comes from count_reg.
    logic ptr_wrap_unused;
    assign ptr_wrap_unused = wr_ptr_reg[AW] ^ rd_ptr_reg[AW];

    assign full         = (count_reg == FULL_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    always_comb begin
        wr_accept   = w_en && !full;
        rd_accept   = r_en && !empty;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
        // A fresh error event wins over a simultaneous clear.
        overflow_next  = (w_en && full)  || (overflow_reg  && !clr_err);
        underflow_next = (r_en && empty) || (underflow_reg && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            assign data_out = empty ? '0 : ram_rdata;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_reg <= '0;
                end else if (rd_accept) begin
                    dout_reg <= ram_rdata;
                end
            end
            assign data_out = dout_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Checks a standard-mode and a fall-through FIFO, driven by the same stimulus,
// against a queue-based model.
module tb_sync_fifo;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, w_en, r_en, clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout_s, dout_f;
    logic          full_s, empty_s, af_s, ae_s, ov_s, un_s;
    logic          full_f, empty_f, af_f, ae_f, ov_f, un_f;
    logic [3:0]    count_s, count_f;

    int total = 0;
    int bad   = 0;
    int cycle_no = 0;

    logic [DW-1:0] q [$];
    logic          m_ov = 1'b0;
    logic          m_un = 1'b0;
    logic [DW-1:0] m_dout = '0;

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(dout_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ov_s), .underflow(un_s)
    );

    sync_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .clr_err(clr_err),
        .data_in(data_in), .data_out(dout_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ov_f), .underflow(un_f)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cycle_no, got, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic [DW-1:0] head;
        n = q.size();
        head = (n != 0) ? q[0] : '0;
        check("count_s", 32'(count_s), 32'(n));
        check("count_f", 32'(count_f), 32'(n));
        check("full_s",  32'(full_s),  32'(n == DEPTH));
        check("full_f",  32'(full_f),  32'(n == DEPTH));
        check("empty_s", 32'(empty_s), 32'(n == 0));
        check("empty_f", 32'(empty_f), 32'(n == 0));
        check("afull",   32'(af_s),    32'(n >= DEPTH - 2));
        check("aempty",  32'(ae_s),    32'(n <= 2));
        check("ovf_s",   32'(ov_s),    32'(m_ov));
        check("udf_s",   32'(un_s),    32'(m_un));
        check("ovf_f",   32'(ov_f),    32'(m_ov));
        check("udf_f",   32'(un_f),    32'(m_un));
        check("dout_s",  32'(dout_s),  32'(m_dout));
        check("dout_f",  32'(dout_f),  32'(head));
    endtask

    // Apply one cycle of stimulus, advance the model, then check 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c,
                       input logic [DW-1:0] d, input logic rs);
        int n;
        rst = rs; w_en = w; r_en = r; clr_err = c; data_in = d;
        @(posedge clk);
        n = q.size();
        if (rs) begin
            q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_dout = '0;
        end else begin
            m_ov = (w && n == DEPTH) || (m_ov && !c);
            m_un = (r && n == 0) || (m_un && !c);
            if (r && n != 0) m_dout = q.pop_front();
            if (w && n != DEPTH) q.push_back(d);
        end
        #1;
        cycle_no++;
        $display("cyc %0d rst=%b w=%b r=%b clr=%b din=%h -> cnt=%0d dout_s=%h dout_f=%h ovf=%b udf=%b",
                 cycle_no, rs, w, r, c, d, count_s, dout_s, dout_f, ov_s, un_s);
        check_all();
    endtask

    initial begin
        cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 1);
        check("rst_empty", 32'(empty_s), 32'd1);

        // Fill to full
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 8'(8'h11 + i), 0);
        check("fill_cnt", 32'(count_s), 32'd8);
        check("fill_full", 32'(full_s), 32'd1);

        // Write while full
        cyc(1, 0, 0, 8'hAA, 0);
        check("ovf_set", 32'(ov_s), 32'd1);
        check("ovf_cnt", 32'(count_s), 32'd8);

        // Drain, one-cycle read latency
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            check("rd_seq", 32'(dout_s), 32'h11 + i);
        end
        check("drain_empty", 32'(empty_s), 32'd1);

        // Read while empty, clear with simultaneous event, then plain clear
        cyc(0, 1, 0, 8'h00, 0);
        check("udf_set", 32'(un_s), 32'd1);
        check("udf_dout_hold", 32'(dout_s), 32'h18);
        cyc(0, 1, 1, 8'h00, 0);
        check("udf_clr_same", 32'(un_s), 32'd1);
        cyc(0, 0, 1, 8'h00, 0);
        check("udf_cleared", 32'(un_s), 32'd0);
        check("ovf_cleared", 32'(ov_s), 32'd0);

        // Steady state at count 4 with pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'(8'h30 + i), 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 8'(8'h40 + i), 0);
        check("wrap_cnt", 32'(count_s), 32'd4);
        check("wrap_order", 32'(dout_s), 32'h4F);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'h00, 0);

        // Fall-through head
        cyc(1, 0, 0, 8'h5A, 0);
        check("fwft_head", 32'(dout_f), 32'h5A);
        cyc(0, 1, 0, 8'h00, 0);
        check("fwft_empty_out", 32'(dout_f), 32'h00);

        // Reset overrides a write mid-operation
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h60 + i), 0);
        cyc(1, 0, 0, 8'h77, 1);
        check("rst_cnt", 32'(count_s), 32'd0);
        check("rst_empty2", 32'(empty_s), 32'd1);

        // Randomized phases with varying write bias
        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            wp = (ph == 0) ? 80 : (ph == 1) ? 20 : (ph == 2) ? 50 : 65;
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(99) < 32'(wp)) ? 1'b1 : 1'b0,
                    ($urandom_range(99) < 32'(100 - wp)) ? 1'b1 : 1'b0,
                    ($urandom_range(15) == 0) ? 1'b1 : 1'b0,
                    8'($urandom),
                    ($urandom_range(199) == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DEPTH, default 8: number of entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_WIDTH, default 8: width of one entry.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 2: almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 0: 0 = standard read mode, 1 = first-word-fall-through mode.
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 rst  input  1  reset; synchronous and active-high.
REQ-008 w_en  input  1  write request.
REQ-009 r_en  input  1  read request (pop).
REQ-010 clr_err  input  1  clears the sticky overflow/underflow flags.
REQ-011 data_in  input  DATA_WIDTH  write data.
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-014 count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-015 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted iff w_en and !full; accepted data is stored at the write address, and the write pointer advances by 1.
REQ-017 Read accepted iff r_en and !empty; the read pointer advances by 1.
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits wide: low bits address the array, MSB is the wrap bit; both wrap modulo 2*DEPTH.
REQ-019 count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 full = (count == DEPTH); empty = (count == 0); almost_full and almost_empty per REQ-003/004; all flags decode only from registered state.
REQ-021 When full, w_en SHALL be dropped even if a read is accepted in the same cycle; memory and the write pointer are unchanged.
REQ-022 When empty, r_en SHALL be ignored even if w_en is accepted in the same cycle.
REQ-023 Simultaneous accepted read and write SHALL leave count and all flags unchanged.
REQ-024 FWFT=0: on an accepted read, data_out SHALL register the entry at the read address (one-cycle latency); otherwise data_out holds its value.
REQ-025 FWFT=1: while !empty, data_out SHALL present the head entry combinationally from the array (zero latency); r_en pops it; while empty, data_out = 0.
REQ-026 overflow SHALL set on the cycle after w_en while full, and underflow on the cycle after r_en while empty; each holds until clr_err.
REQ-027 clr_err and a new error event in the same cycle: the flag SHALL remain set.

Reset
REQ-028 When rst=1 at a clock edge, pointers, count, overflow, underflow and the registered data_out SHALL become 0; empty=1, almost_empty=1, full=0, almost_full=0.
REQ-029 Reset SHALL override any simultaneous w_en, r_en or clr_err.
REQ-030 Reset mid-operation discards all contents; the array is not cleared.

Structure
REQ-031 Package fifo_pkg holds the pointer-width function and the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1).
REQ-032 Storage SHALL be one sub-module, fifo_ram: a synchronous-write, asynchronous-read array of DEPTH x DATA_WIDTH.
REQ-033 Pointer, count and flag logic SHALL live in sync_fifo.

Verification
REQ-034 DEPTH=8, FWFT=0: write 0x11..0x18 -> full=1, count=8, almost_full from count 6; read 8 -> data_out 0x11..0x18, each one cycle after its r_en; then empty=1.
REQ-035 Full, w_en=1 with data 0xAA -> count stays 8, overflow=1 the next cycle; a later read returns the original data, not 0xAA.
REQ-036 Empty, r_en=1 -> underflow=1, data_out unchanged; pulse clr_err -> underflow=0 the next cycle.
REQ-037 count=4, w_en=r_en=1 for 20 cycles (pointers wrap) -> count stays 4 and data order is preserved.
REQ-038 FWFT=1: write 0x5A into an empty FIFO -> the next cycle empty=0 and data_out=0x5A with no r_en; r_en -> empty=1 and data_out=0.
REQ-039 rst=1 with count=5 and w_en=1 -> the next cycle count=0 and empty=1.
